serdes_word_align: RTL and testbench

//  Parametrised 10b word aligner for the SerDes RX path; sits between the deserializer and Dec8b10b.

---
 rtl/serdes_word_align_pkg.sv | 18 +
 rtl/serdes_word_align_if.sv | 29 ++
 rtl/serdes_comma_detect.sv | 28 ++
 rtl/serdes_word_align.sv | 191 +++++++++++++++++++
 tb/tb_serdes_word_align.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/serdes_word_align_pkg.sv
// Shared constants and types for the 10b word aligner.
package serdes_pkg;

  // K28.5 with symbol bit a at the LSB, both running disparities.
  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  function automatic logic is_k28_5(input logic [9:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

endpackage

// File: rtl/serdes_word_align_if.sv
// Aligner data/control bundle: deserializer side drives, aligner answers.
interface serdes_word_align_if #(
  parameter int SYM_N = 2
);
  localparam int DW = 10 * SYM_N;
  localparam int OW = $clog2(DW);

  logic             enable;
  logic [DW-1:0]    data_in;
  logic             data_in_valid;
  logic [SYM_N-1:0] code_err_in;
  logic [DW-1:0]    data_out;
  logic             data_out_valid;
  logic [SYM_N-1:0] comma_out;
  logic [OW-1:0]    align_offset;
  logic             bit_align_done;
  logic             realign;

  modport master (
    output enable, data_in, data_in_valid, code_err_in,
    input  data_out, data_out_valid, comma_out, align_offset, bit_align_done, realign
  );

  modport slave (
    input  enable, data_in, data_in_valid, code_err_in,
    output data_out, data_out_valid, comma_out, align_offset, bit_align_done, realign
  );

endinterface

// File: rtl/serdes_comma_detect.sv
// Combinational K28.5 search over every bit offset of the history window.
module serdes_comma_detect
  import serdes_pkg::*;
#(
  parameter int SYM_N = 2,
  localparam int DW   = 10 * SYM_N,
  localparam int OW   = $clog2(DW)
) (
  input  logic [DW+8:0] win_bits,
  output logic [DW-1:0] hit,
  output logic          any_hit,
  output logic [OW-1:0] low_idx
);

  // Match each 10b window, then pick the lowest matching offset.
  always_comb begin
    hit     = '0;
    low_idx = '0;
    for (int p = 0; p < DW; p++) begin
      hit[p] = is_k28_5(win_bits[p +: 10]);
    end
    for (int p = DW - 1; p >= 0; p--) begin
      if (hit[p]) low_idx = OW'(p);
    end
    any_hit = |hit;
  end

endmodule

// File: rtl/serdes_word_align.sv
// 10b word aligner: hunts K28.5 at every bit offset, verifies, locks and
// emits symbol-aligned words until too many consecutive bad words arrive.
module serdes_word_align
  import serdes_pkg::*;
#(
  parameter int SYM_N       = 2,
  parameter int LOCK_CNT    = 3,
  parameter int UNLOCK_CNT  = 4,
  parameter int COMMA_LANE0 = 1
) (
  input logic clk,
  input logic rst_n,
  serdes_word_align_if.slave bus
);

  localparam int DW = 10 * SYM_N;
  localparam int OW = $clog2(DW);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] LOCK_FULL   = CW'(LOCK_CNT);
  localparam logic [EW-1:0] UNLOCK_LAST = EW'(UNLOCK_CNT - 1);

  align_state_t  state_q, state_n;
  logic [OW-1:0] off_q, off_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [EW-1:0] err_q, err_n;
  logic          unlock;

  logic [DW-1:0]     prev_p0;
  logic [2*DW-1:0]   hist;
  logic [DW-1:0]     hit;
  logic              any_hit;
  logic [OW-1:0]     low_idx;
  logic [OW-1:0]     low_off;
  logic              aligned_hit;
  logic              misaligned_hit;

  logic [DW-1:0]     data_nxt;
  logic [SYM_N-1:0]  comma_nxt;
  logic              vld_nxt;
  logic [DW-1:0]     data_p1;
  logic [SYM_N-1:0]  comma_p1;
  logic              vld_p1;
  logic              realign_p1;

  assign hist = {bus.data_in, prev_p0};

  serdes_comma_detect #(.SYM_N(SYM_N)) u_detect (
    .win_bits (hist[DW+8:0]),
    .hit      (hit),
    .any_hit  (any_hit),
    .low_idx  (low_idx)
  );

  assign low_off = (COMMA_LANE0 != 0) ? low_idx : OW'(int'(low_idx) % 10);

  // Classify hits against the current offset. A comma at the locked bit
  // phase but in another lane is neither aligned nor a misalignment.
  always_comb begin
    aligned_hit    = 1'b0;
    misaligned_hit = 1'b0;
    for (int p = 0; p < DW; p++) begin
      if (hit[p]) begin
        if ((p % 10) != (int'(off_q) % 10)) begin
          misaligned_hit = 1'b1;
        end else if ((COMMA_LANE0 == 0) || (p == int'(off_q))) begin
          aligned_hit = 1'b1;
        end
      end
    end
  end

  // Next-state and counter logic; only valid words move the FSM.
  always_comb begin
    state_n = state_q;
    off_n   = off_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    unlock  = 1'b0;
    if (bus.data_in_valid) begin
      if (!bus.enable) begin
        state_n = HUNT;
        cnt_n   = '0;
        err_n   = '0;
      end else begin
        case (state_q)
          HUNT: begin
            if (any_hit) begin
              off_n   = low_off;
              cnt_n   = CW'(1);
              err_n   = '0;
              state_n = (LOCK_CNT == 1) ? LOCKED : VERIFY;
            end
          end
          VERIFY: begin
            if (aligned_hit) begin
              if (cnt_q >= LOCK_LAST) begin
                cnt_n   = LOCK_FULL;
                err_n   = '0;
                state_n = LOCKED;
              end else begin
                cnt_n = cnt_q + 1'b1;
              end
            end else if (misaligned_hit) begin
              off_n = low_off;
              cnt_n = CW'(1);
            end
          end
          LOCKED: begin
            if ((|bus.code_err_in) || misaligned_hit) begin
              if (err_q >= UNLOCK_LAST) begin
                state_n = HUNT;
                cnt_n   = '0;
                err_n   = '0;
                unlock  = 1'b1;
              end else begin
                err_n = err_q + 1'b1;
              end
            end else begin
              err_n = '0;
            end
          end
          default: begin
            state_n = HUNT;
            cnt_n   = '0;
            err_n   = '0;
          end
        endcase
      end
    end
  end

  // Output word selection uses the offset this word leaves behind, so the
  // lock-completing word is already aligned.
  always_comb begin
    data_nxt  = hist[off_n +: DW];
    comma_nxt = '0;
    for (int k = 0; k < SYM_N; k++) begin
      for (int p = 0; p < DW; p++) begin
        if (p == int'(off_n) + 10 * k) comma_nxt[k] = hit[p];
      end
    end
    vld_nxt = bus.data_in_valid && bus.enable &&
              ((state_q == LOCKED) || (state_n == LOCKED));
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      off_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_n;
      off_q   <= off_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
    end
  end

  // p0 -> p1: history capture and registered outputs, advanced per valid word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p0    <= '0;
      data_p1    <= '0;
      comma_p1   <= '0;
      vld_p1     <= 1'b0;
      realign_p1 <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      realign_p1 <= 1'b0;
      if (bus.data_in_valid) begin
        prev_p0    <= bus.data_in;
        data_p1    <= data_nxt;
        comma_p1   <= comma_nxt;
        vld_p1     <= vld_nxt;
        realign_p1 <= unlock;
      end
    end
  end

  assign bus.data_out       = data_p1;
  assign bus.comma_out      = comma_p1;
  assign bus.data_out_valid = vld_p1;
  assign bus.realign        = realign_p1;
  assign bus.align_offset   = off_q;
  assign bus.bit_align_done = (state_q == LOCKED);

endmodule

// File: tb/tb_serdes_word_align.sv
// Directed bench for serdes_word_align (SYM_N=2, LOCK_CNT=3, UNLOCK_CNT=4, COMMA_LANE0=1).
module tb_serdes_word_align;

  localparam logic [9:0] KN = 10'h17C;
  localparam logic [9:0] KP = 10'h283;

  logic clk = 1'b0;
  logic rst_n;
  int   n_err = 0;
  int   n_checks = 0;
  bit   bq[$];
  logic [19:0] kk;
  logic [19:0] pk;

  serdes_word_align_if #(.SYM_N(2)) bus ();

  serdes_word_align dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) bq.push_back(s[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) bq.push_back(1'b0);
  endtask

  // Present one 20-bit word from the bit stream, then sample 1 ns after the edge.
  task automatic word(input logic en, input logic [1:0] cerr);
    logic [19:0] w;
    for (int i = 0; i < 20; i++) w[i] = (bq.size() > 0) ? bq.pop_front() : 1'b0;
    bus.data_in       = w;
    bus.data_in_valid = 1'b1;
    bus.enable        = en;
    bus.code_err_in   = cerr;
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    bus.code_err_in   = 2'b00;
  endtask

  task automatic gap();
    bus.data_in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bq.delete();
    bus.data_in_valid = 1'b0;
    bus.code_err_in   = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    kk = {KN, KN};
    pk = {KP, KN};
    rst_n             = 1'b0;
    bus.enable        = 1'b0;
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    bus.code_err_in   = 2'b00;
    @(posedge clk);
    #1;
    chk("rst data_out", bus.data_out, 0);
    chk("rst valid", bus.data_out_valid, 0);
    chk("rst comma", bus.comma_out, 0);
    chk("rst offset", bus.align_offset, 0);
    chk("rst done", bus.bit_align_done, 0);
    chk("rst realign", bus.realign, 0);
    rst_n = 1'b1;

    // K28.5 RD- repeated at bit shift 3
    push_zeros(3);
    repeat (40) push_sym(KN);
    word(1'b1, 2'b00);
    chk("A w1 valid", bus.data_out_valid, 0);
    chk("A w1 done", bus.bit_align_done, 0);
    word(1'b1, 2'b00);
    chk("A w2 offset", bus.align_offset, 3);
    chk("A w2 done", bus.bit_align_done, 0);
    word(1'b1, 2'b00);
    chk("A w3 done", bus.bit_align_done, 0);
    word(1'b1, 2'b00);
    chk("A w4 done", bus.bit_align_done, 1);
    chk("A w4 valid", bus.data_out_valid, 1);
    chk("A w4 data", bus.data_out, kk);
    chk("A w4 comma", bus.comma_out, 2'b11);
    chk("A w4 realign", bus.realign, 0);
    gap();
    chk("A gap valid", bus.data_out_valid, 0);
    chk("A gap done", bus.bit_align_done, 1);
    chk("A gap data", bus.data_out, kk);

    // Locked error counting
    for (int i = 0; i < 3; i++) begin
      word(1'b1, 2'b10);
      chk("D cerr done", bus.bit_align_done, 1);
      chk("D cerr valid", bus.data_out_valid, 1);
    end
    word(1'b1, 2'b00);
    chk("D clean done", bus.bit_align_done, 1);
    for (int i = 0; i < 3; i++) begin
      word(1'b1, 2'b01);
      chk("D bad done", bus.bit_align_done, 1);
      chk("D bad realign", bus.realign, 0);
    end
    word(1'b1, 2'b01);
    chk("D 4th bad done", bus.bit_align_done, 0);
    chk("D 4th bad realign", bus.realign, 1);
    chk("D 4th bad valid", bus.data_out_valid, 1);
    word(1'b1, 2'b00);
    chk("D after realign", bus.realign, 0);
    chk("D after valid", bus.data_out_valid, 0);
    chk("D after done", bus.bit_align_done, 0);

    // Mixed disparity at shift 13
    do_reset();
    push_zeros(13);
    repeat (20) begin
      push_sym(KN);
      push_sym(KP);
    end
    word(1'b1, 2'b00);
    word(1'b1, 2'b00);
    chk("B w2 offset", bus.align_offset, 13);
    word(1'b1, 2'b00);
    chk("B w3 done", bus.bit_align_done, 0);
    for (int i = 0; i < 3; i++) begin
      word(1'b1, 2'b00);
      chk("B lock done", bus.bit_align_done, 1);
      chk("B lock valid", bus.data_out_valid, 1);
      chk("B lock data", bus.data_out, pk);
      chk("B lock comma", bus.comma_out, 2'b01);
      chk("B lock offset", bus.align_offset, 13);
    end

    // VERIFY restart on a phase jump from 3 to 7
    do_reset();
    push_zeros(3);
    repeat (4) push_sym(KN);
    push_zeros(4);
    repeat (20) push_sym(KN);
    word(1'b1, 2'b00);
    word(1'b1, 2'b00);
    chk("C w2 offset", bus.align_offset, 3);
    word(1'b1, 2'b00);
    chk("C w3 offset", bus.align_offset, 3);
    chk("C w3 done", bus.bit_align_done, 0);
    word(1'b1, 2'b00);
    chk("C w4 offset", bus.align_offset, 7);
    chk("C w4 done", bus.bit_align_done, 0);
    word(1'b1, 2'b00);
    chk("C w5 done", bus.bit_align_done, 0);
    word(1'b1, 2'b00);
    chk("C w6 done", bus.bit_align_done, 1);
    chk("C w6 offset", bus.align_offset, 7);
    chk("C w6 data", bus.data_out, kk);

    // Gaps and enable low
    do_reset();
    push_zeros(3);
    repeat (40) push_sym(KN);
    word(1'b1, 2'b00);
    word(1'b1, 2'b00);
    chk("E w2 offset", bus.align_offset, 3);
    gap();
    chk("E gap done", bus.bit_align_done, 0);
    chk("E gap offset", bus.align_offset, 3);
    word(1'b1, 2'b00);
    chk("E w3 done", bus.bit_align_done, 0);
    word(1'b0, 2'b00);
    chk("E dis done", bus.bit_align_done, 0);
    chk("E dis realign", bus.realign, 0);
    chk("E dis valid", bus.data_out_valid, 0);
    word(1'b1, 2'b00);
    chk("E w5 done", bus.bit_align_done, 0);
    word(1'b1, 2'b00);
    chk("E w6 done", bus.bit_align_done, 0);
    word(1'b1, 2'b00);
    chk("E w7 done", bus.bit_align_done, 1);
    word(1'b0, 2'b00);
    chk("E lock dis done", bus.bit_align_done, 0);
    chk("E lock dis realign", bus.realign, 0);
    chk("E lock dis valid", bus.data_out_valid, 0);

    // Asynchronous reset while locked, then relock
    word(1'b1, 2'b00);
    word(1'b1, 2'b00);
    word(1'b1, 2'b00);
    chk("F pre-reset done", bus.bit_align_done, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("F async done", bus.bit_align_done, 0);
    chk("F async valid", bus.data_out_valid, 0);
    chk("F async data", bus.data_out, 0);
    chk("F async offset", bus.align_offset, 0);
    chk("F async comma", bus.comma_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      word(1'b1, 2'b00);
      chk("F relock early done", bus.bit_align_done, 0);
    end
    word(1'b1, 2'b00);
    chk("F relock done", bus.bit_align_done, 1);
    chk("F relock offset", bus.align_offset, 3);
    chk("F relock data", bus.data_out, kk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
